// File: rtl/mem_stage_bus_pkg.sv
// Shared definitions for the memory-access stage: op codes, exception codes,
// FSM state encoding and the MEM/WB control payload.
package mem_stage_bus_pkg;

    // Memory op codes as they arrive from the execute stage.
    localparam logic [7:0] OP_LB = 8'h90;
    localparam logic [7:0] OP_LW = 8'h92;
    localparam logic [7:0] OP_SB = 8'h98;
    localparam logic [7:0] OP_SW = 8'h9A;

    // Exception codes reported alongside mem_exc_o.
    localparam logic [1:0] MEXC_NONE  = 2'b00;
    localparam logic [1:0] MEXC_ALIGN = 2'b01;
    localparam logic [1:0] MEXC_BUS   = 2'b10;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Control fields registered into the MEM/WB boundary.
    typedef struct packed {
        logic [4:0] wa;
        logic       wreg;
        logic       whilo;
        logic       mreg;
        logic [3:0] dre;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_bus_align.sv
// Byte-lane formatting for data-memory accesses (purely combinational).
// Ports:
//   aluop_i    op code
//   addr_lo_i  effective address bits [1:0]
//   rt_i       store data
//   is_load_o  op is LB/LW
//   is_store_o op is SB/SW
//   we_o       byte-lane write strobes
//   din_o      lane-formatted write data
//   dre_o      read lanes for loads
//   misal_o    word access with a non-zero byte offset
module mem_stage_bus_align
    import mem_stage_bus_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rt_i,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic [3:0]  we_o,
    output logic [31:0] din_o,
    output logic [3:0]  dre_o,
    output logic        misal_o
);

    // Decode op and place data on lane k = addr[1:0].
    always_comb begin
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        we_o       = 4'b0000;
        din_o      = 32'h0;
        dre_o      = 4'b0000;
        misal_o    = 1'b0;
        case (aluop_i)
            OP_LB: begin
                is_load_o = 1'b1;
                dre_o     = 4'b0001 << addr_lo_i;
            end
            OP_LW: begin
                is_load_o = 1'b1;
                dre_o     = 4'b1111;
                misal_o   = (addr_lo_i != 2'b00);
            end
            OP_SB: begin
                is_store_o = 1'b1;
                we_o       = 4'b0001 << addr_lo_i;
                din_o      = {4{rt_i[7:0]}};
            end
            OP_SW: begin
                is_store_o = 1'b1;
                we_o       = 4'b1111;
                // Word stores go out byte-reversed onto the bus.
                din_o      = {rt_i[7:0], rt_i[15:8], rt_i[23:16], rt_i[31:24]};
                misal_o    = (addr_lo_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_bus.sv
// Memory-access stage: drives a req/ack data-memory bus for LB/LW/SB/SW,
// stalls upstream while waiting, and registers results into MEM/WB.
// Ports:
//   cpu_clk_50M, cpu_rst          clock, async active-high reset
//   mem_*_i                       instruction fields from execute
//   mem_stall_o                   hold upstream
//   dce_o/daddr_o/we_o/din_o      bus request (combinational)
//   dack_i/drdata_i               bus response
//   wb_*_o                        registered MEM/WB outputs
//   mem_exc_o/mem_exc_code_o      exception pulse and code
module mem_stage_bus
    import mem_stage_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        mem_valid_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [4:0]  mem_wa_i,
    input  logic        mem_wreg_i,
    input  logic        mem_whilo_i,
    input  logic        mem_mreg_i,
    input  logic [31:0] mem_wd_i,
    input  logic [31:0] mem_din_i,
    input  logic [63:0] mem_hilo_i,
    output logic        mem_stall_o,
    output logic        dce_o,
    output logic [31:0] daddr_o,
    output logic [3:0]  we_o,
    output logic [31:0] din_o,
    input  logic        dack_i,
    input  logic [31:0] drdata_i,
    output logic [4:0]  wb_wa_o,
    output logic        wb_wreg_o,
    output logic        wb_whilo_o,
    output logic        wb_mreg_o,
    output logic [31:0] wb_dreg_o,
    output logic [63:0] wb_dhilo_o,
    output logic [3:0]  wb_dre_o,
    output logic [31:0] wb_dm_o,
    output logic        mem_exc_o,
    output logic [1:0]  mem_exc_code_o
);

    logic        is_load, is_store, misal;
    logic [3:0]  al_we, al_dre;
    logic [31:0] al_din;

    mem_stage_bus_align u_align (
        .aluop_i    (mem_aluop_i),
        .addr_lo_i  (mem_wd_i[1:0]),
        .rt_i       (mem_din_i),
        .is_load_o  (is_load),
        .is_store_o (is_store),
        .we_o       (al_we),
        .din_o      (al_din),
        .dre_o      (al_dre),
        .misal_o    (misal)
    );

    logic memop, misal_v, go;
    assign memop   = mem_valid_i & (is_load | is_store);
    assign misal_v = memop & misal;
    assign go      = memop & ~misal;

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             at_max, abort, bus_en, complete;

    assign at_max = (wait_cnt_q == CNT_W'(MAX_WAIT));

    // State register and wait counter.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q    <= MEM_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state; the counter is never advanced past MAX_WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            MEM_IDLE: begin
                if (go && !dack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Leaving WAIT on ack, on timeout, or if the request vanishes.
                if (!go || dack_i || at_max) begin
                    state_d    = MEM_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = MEM_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Bus outputs and stall; all forced low while reset is asserted.
    always_comb begin
        abort       = (state_q == MEM_WAIT) & go & ~dack_i & at_max;
        bus_en      = go & ~abort & ~cpu_rst;
        complete    = bus_en & dack_i;
        mem_stall_o = bus_en & ~dack_i;
        dce_o       = bus_en;
        daddr_o     = bus_en ? {mem_wd_i[31:2], 2'b00} : 32'h0;
        we_o        = bus_en ? al_we : 4'b0000;
        din_o       = bus_en ? al_din : 32'h0;
    end

    wb_ctrl_t    wb_ctrl_q, wb_ctrl_d;
    logic [31:0] dreg_q, dreg_d, dm_q, dm_d;
    logic [63:0] dhilo_q, dhilo_d;
    logic        exc_q, exc_d;
    logic [1:0]  exc_code_q, exc_code_d;

    // MEM/WB next values; anything not completing or passing through is a bubble.
    always_comb begin
        wb_ctrl_d  = WB_BUBBLE;
        dreg_d     = dreg_q;
        dhilo_d    = dhilo_q;
        dm_d       = dm_q;
        exc_d      = 1'b0;
        exc_code_d = MEXC_NONE;
        if (misal_v) begin
            exc_d      = 1'b1;
            exc_code_d = MEXC_ALIGN;
        end else if (abort) begin
            exc_d      = 1'b1;
            exc_code_d = MEXC_BUS;
        end else if (complete) begin
            wb_ctrl_d.wa    = mem_wa_i;
            wb_ctrl_d.wreg  = mem_wreg_i & is_load;
            wb_ctrl_d.whilo = mem_whilo_i;
            wb_ctrl_d.mreg  = mem_mreg_i;
            wb_ctrl_d.dre   = al_dre;
            dreg_d          = mem_wd_i;
            dhilo_d         = mem_hilo_i;
            if (is_load) begin
                dm_d = drdata_i;
            end
        end else if (mem_valid_i && !memop) begin
            wb_ctrl_d.wa    = mem_wa_i;
            wb_ctrl_d.wreg  = mem_wreg_i;
            wb_ctrl_d.whilo = mem_whilo_i;
            wb_ctrl_d.mreg  = mem_mreg_i;
            dreg_d          = mem_wd_i;
            dhilo_d         = mem_hilo_i;
        end
    end

    // MEM/WB boundary registers.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            wb_ctrl_q  <= WB_BUBBLE;
            dreg_q     <= '0;
            dhilo_q    <= '0;
            dm_q       <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= MEXC_NONE;
        end else begin
            wb_ctrl_q  <= wb_ctrl_d;
            dreg_q     <= dreg_d;
            dhilo_q    <= dhilo_d;
            dm_q       <= dm_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    assign wb_wa_o        = wb_ctrl_q.wa;
    assign wb_wreg_o      = wb_ctrl_q.wreg;
    assign wb_whilo_o     = wb_ctrl_q.whilo;
    assign wb_mreg_o      = wb_ctrl_q.mreg;
    assign wb_dre_o       = wb_ctrl_q.dre;
    assign wb_dreg_o      = dreg_q;
    assign wb_dhilo_o     = dhilo_q;
    assign wb_dm_o        = dm_q;
    assign mem_exc_o      = exc_q;
    assign mem_exc_code_o = exc_code_q;

endmodule

// File: tb/tb_mem_stage_bus.sv
// Testbench for mem_stage_bus: directed scenarios followed by random
// instruction streams, checked against a transaction-level reference model.
module tb_mem_stage_bus;
    import mem_stage_bus_pkg::*;

    localparam int         MAX_WAIT = 15;
    localparam logic [7:0] OP_ADDU  = 8'h21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic [7:0]  mem_aluop_i = 8'h0;
    logic [4:0]  mem_wa_i = 5'h0;
    logic        mem_wreg_i = 1'b0, mem_whilo_i = 1'b0, mem_mreg_i = 1'b0;
    logic [31:0] mem_wd_i = 32'h0, mem_din_i = 32'h0;
    logic [63:0] mem_hilo_i = 64'h0;
    logic        dack_i = 1'b0;
    logic [31:0] drdata_i = 32'h0;

    logic        mem_stall_o, dce_o;
    logic [31:0] daddr_o, din_o;
    logic [3:0]  we_o;
    logic [4:0]  wb_wa_o;
    logic        wb_wreg_o, wb_whilo_o, wb_mreg_o;
    logic [31:0] wb_dreg_o, wb_dm_o;
    logic [63:0] wb_dhilo_o;
    logic [3:0]  wb_dre_o;
    logic        mem_exc_o;
    logic [1:0]  mem_exc_code_o;

    int checks = 0;
    int errors = 0;

    // Model of the held MEM/WB data registers.
    logic [31:0] e_dreg = 32'h0, e_dm = 32'h0;
    logic [63:0] e_dhilo = 64'h0;

    mem_stage_bus #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .cpu_clk_50M    (clk),
        .cpu_rst        (rst),
        .mem_valid_i    (mem_valid_i),
        .mem_aluop_i    (mem_aluop_i),
        .mem_wa_i       (mem_wa_i),
        .mem_wreg_i     (mem_wreg_i),
        .mem_whilo_i    (mem_whilo_i),
        .mem_mreg_i     (mem_mreg_i),
        .mem_wd_i       (mem_wd_i),
        .mem_din_i      (mem_din_i),
        .mem_hilo_i     (mem_hilo_i),
        .mem_stall_o    (mem_stall_o),
        .dce_o          (dce_o),
        .daddr_o        (daddr_o),
        .we_o           (we_o),
        .din_o          (din_o),
        .dack_i         (dack_i),
        .drdata_i       (drdata_i),
        .wb_wa_o        (wb_wa_o),
        .wb_wreg_o      (wb_wreg_o),
        .wb_whilo_o     (wb_whilo_o),
        .wb_mreg_o      (wb_mreg_o),
        .wb_dreg_o      (wb_dreg_o),
        .wb_dhilo_o     (wb_dhilo_o),
        .wb_dre_o       (wb_dre_o),
        .wb_dm_o        (wb_dm_o),
        .mem_exc_o      (mem_exc_o),
        .mem_exc_code_o (mem_exc_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every registered output against the model.
    task automatic chk_wb(input string tag, input logic [4:0] wa, input logic wreg,
                          input logic whilo, input logic mreg, input logic [3:0] dre,
                          input logic exc, input logic [1:0] code);
        chk({tag, ".wa"},    64'(wb_wa_o),        64'(wa));
        chk({tag, ".wreg"},  64'(wb_wreg_o),      64'(wreg));
        chk({tag, ".whilo"}, 64'(wb_whilo_o),     64'(whilo));
        chk({tag, ".mreg"},  64'(wb_mreg_o),      64'(mreg));
        chk({tag, ".dre"},   64'(wb_dre_o),       64'(dre));
        chk({tag, ".exc"},   64'(mem_exc_o),      64'(exc));
        chk({tag, ".code"},  64'(mem_exc_code_o), 64'(code));
        chk({tag, ".dreg"},  64'(wb_dreg_o),      64'(e_dreg));
        chk({tag, ".dhilo"}, wb_dhilo_o,          e_dhilo);
        chk({tag, ".dm"},    64'(wb_dm_o),        64'(e_dm));
    endtask

    // Present one instruction (called just after a rising edge) and follow it
    // to retirement. ack_at: cycle index of dack_i, -1 for never.
    task automatic run_op(input string tag, input logic v, input logic [7:0] op,
                          input logic [4:0] wa, input logic wreg, input logic whilo,
                          input logic mreg, input logic [31:0] wd, input logic [31:0] rt,
                          input logic [63:0] hilo, input int ack_at, input logic [31:0] rdata);
        logic       is_ld, is_st, mem, mis, fin, abrt, e_dce, e_stall;
        logic [1:0] k;
        logic [3:0] x_we, x_dre;
        logic [31:0] x_din;
        is_ld = v && (op == OP_LB || op == OP_LW);
        is_st = v && (op == OP_SB || op == OP_SW);
        mem   = is_ld || is_st;
        k     = wd[1:0];
        mis   = mem && (op == OP_LW || op == OP_SW) && (k != 2'b00);
        x_we  = (op == OP_SB) ? (4'b0001 << k) : (op == OP_SW) ? 4'b1111 : 4'b0000;
        x_dre = (op == OP_LB) ? (4'b0001 << k) : (op == OP_LW) ? 4'b1111 : 4'b0000;
        x_din = 32'h0;
        if (op == OP_SB) x_din = {4{rt[7:0]}};
        if (op == OP_SW) for (int b = 0; b < 4; b++) x_din[8*b +: 8] = rt[8*(3-b) +: 8];

        mem_valid_i = v;    mem_aluop_i = op;     mem_wa_i   = wa;
        mem_wreg_i  = wreg; mem_whilo_i = whilo;  mem_mreg_i = mreg;
        mem_wd_i    = wd;   mem_din_i   = rt;     mem_hilo_i = hilo;

        fin = 1'b0;
        for (int c = 0; c <= MAX_WAIT && !fin; c++) begin
            abrt = 1'b0;
            if (mem && !mis) begin
                dack_i  = (c == ack_at);
                abrt    = !dack_i && (c == MAX_WAIT);
                e_dce   = !abrt;
                e_stall = !dack_i && !abrt;
                fin     = dack_i || abrt;
            end else begin
                dack_i  = 1'($urandom_range(0, 1));
                e_dce   = 1'b0;
                e_stall = 1'b0;
                fin     = 1'b1;
            end
            drdata_i = dack_i ? rdata : $urandom;
            @(negedge clk);
            chk({tag, ".dce"},   64'(dce_o),       64'(e_dce));
            chk({tag, ".stall"}, 64'(mem_stall_o), 64'(e_stall));
            chk({tag, ".daddr"}, 64'(daddr_o),     64'(e_dce ? {wd[31:2], 2'b00} : 32'h0));
            chk({tag, ".we"},    64'(we_o),        64'(e_dce ? x_we : 4'b0000));
            chk({tag, ".din"},   64'(din_o),       64'(e_dce ? x_din : 32'h0));
            @(posedge clk);
            #1;
            if (!fin || !v || mis || abrt) begin
                chk_wb(tag, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, mis || abrt,
                       mis ? MEXC_ALIGN : (abrt ? MEXC_BUS : MEXC_NONE));
            end else begin
                e_dreg  = wd;
                e_dhilo = hilo;
                if (is_ld) e_dm = rdata;
                if (mem) chk_wb(tag, wa, wreg && is_ld, whilo, mreg, x_dre, 1'b0, MEXC_NONE);
                else     chk_wb(tag, wa, wreg, whilo, mreg, 4'b0000, 1'b0, MEXC_NONE);
            end
        end
        dack_i = 1'b0;
    endtask

    initial begin
        // Reset state.
        #12;
        chk("rst.dce", 64'(dce_o), 64'(0));
        chk("rst.stall", 64'(mem_stall_o), 64'(0));
        chk_wb("rst", 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, MEXC_NONE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed scenarios.
        run_op("addu", 1'b1, OP_ADDU, 5'd3, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 64'h0, 0, 32'h0);
        run_op("lw3", 1'b1, OP_LW, 5'd4, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 64'h11, 3, 32'h78563412);
        run_op("sb0", 1'b1, OP_SB, 5'd5, 1'b1, 1'b0, 1'b0, 32'h203, 32'hAB, 64'h22, 0, 32'h0);
        run_op("lb1", 1'b1, OP_LB, 5'd6, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 64'h33, 1, 32'h0000F000);
        run_op("swmis", 1'b1, OP_SW, 5'd7, 1'b1, 1'b0, 1'b0, 32'h102, 32'hCAFE, 64'h44, 0, 32'h0);
        run_op("sw", 1'b1, OP_SW, 5'd7, 1'b1, 1'b1, 1'b0, 32'h400, 32'h11223344, 64'h55, 2, 32'h0);
        run_op("lwmax", 1'b1, OP_LW, 5'd8, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 64'h66, MAX_WAIT, 32'hA5A5_0F0F);
        run_op("lwto", 1'b1, OP_LW, 5'd9, 1'b1, 1'b0, 1'b1, 32'h108, 32'h0, 64'h77, -1, 32'h0);
        run_op("idle", 1'b0, OP_LW, 5'd9, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h0, 64'h88, 0, 32'h0);

        // Reset during a pending load.
        mem_valid_i = 1'b1; mem_aluop_i = OP_LW; mem_wd_i = 32'h300; dack_i = 1'b0;
        @(negedge clk);
        chk("prerst.stall", 64'(mem_stall_o), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        e_dreg = 32'h0; e_dhilo = 64'h0; e_dm = 32'h0;
        #1;
        chk("midrst.dce", 64'(dce_o), 64'(0));
        chk("midrst.stall", 64'(mem_stall_o), 64'(0));
        chk("midrst.daddr", 64'(daddr_o), 64'(0));
        chk_wb("midrst", 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, MEXC_NONE);
        @(posedge clk);
        #1;
        chk_wb("rsthold", 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, MEXC_NONE);
        rst = 1'b0;
        run_op("postrst", 1'b1, OP_LW, 5'd10, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 64'h99, 2, 32'hDEADBEEF);

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            logic [7:0]  op;
            logic [31:0] wd;
            int          sel, ack;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    op = OP_LB;
                2, 3:    op = OP_LW;
                4:       op = OP_SB;
                5:       op = OP_SW;
                6:       op = 8'h0C;
                default: op = OP_ADDU;
            endcase
            wd = $urandom;
            if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 1) == 0) wd[1:0] = 2'b00;
            ack = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            run_op("rnd", 1'($urandom_range(0, 7) != 0), op, 5'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), wd, $urandom, {$urandom, $urandom}, ack, $urandom);
        end

        mem_valid_i = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
